// File: rtl/mem64_to32_bridge_pkg.sv
// Shared types and constants for the 64-to-32 bit memory bridge.
// Narrow-address LSB selects the half: HI (bits 63:32) first, then LO.
package mem64_to32_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrHi,
        StWrLo,
        StRdHi,
        StRdLo,
        StRdCap,
        StRsp
    } state_e;

    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

endpackage

// File: rtl/mem64_to32_bridge.sv
// Downsizes single 64-bit read/write requests into up to two 32-bit narrow-port accesses.
// Optional feature macro BRIDGE_WR_ACK_EN: writes also return a one-cycle rsp_valid pulse.
module mem64_to32_bridge
    import mem64_to32_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [7:0]            req_byte_en,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [63:0]           rsp_rdata,
    output logic                  mem_we,
    output logic                  mem_rd,
    output logic [3:0]            mem_byte_en,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

`ifdef BRIDGE_WR_ACK_EN
    localparam state_e WrDone = StRsp;
`else
    localparam state_e WrDone = StIdle;
`endif

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            be_reg;
    logic [63:0]           wdata_reg;
    logic [31:0]           hi_reg;
    logic                  accept;

    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == StRsp);

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_rd      = 1'b0;
        mem_byte_en = 4'h0;
        mem_addr    = '0;
        mem_wdata   = 32'h0;
        case (state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_we) begin
                        // An empty HI half skips straight to the LO beat.
                        state_next = (|req_byte_en[7:4]) ? StWrHi : StWrLo;
                    end else begin
                        state_next = StRdHi;
                    end
                end
            end
            StWrHi: begin
                mem_we      = 1'b1;
                mem_byte_en = be_reg[7:4];
                mem_addr    = {addr_reg, HALF_HI};
                mem_wdata   = wdata_reg[63:32];
                state_next  = (|be_reg[3:0]) ? StWrLo : WrDone;
            end
            StWrLo: begin
                // Also reached by an all-zero write, which must stay silent here.
                if (|be_reg[3:0]) begin
                    mem_we      = 1'b1;
                    mem_byte_en = be_reg[3:0];
                    mem_addr    = {addr_reg, HALF_LO};
                    mem_wdata   = wdata_reg[31:0];
                end
                state_next = WrDone;
            end
            StRdHi: begin
                mem_rd      = 1'b1;
                mem_byte_en = 4'hF;
                mem_addr    = {addr_reg, HALF_HI};
                state_next  = StRdLo;
            end
            StRdLo: begin
                mem_rd      = 1'b1;
                mem_byte_en = 4'hF;
                mem_addr    = {addr_reg, HALF_LO};
                state_next  = StRdCap;
            end
            StRdCap: begin
                state_next = StRsp;
            end
            StRsp: begin
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            be_reg    <= 8'h0;
            wdata_reg <= 64'h0;
        end else if (accept) begin
            addr_reg  <= req_addr;
            be_reg    <= req_byte_en;
            wdata_reg <= req_wdata;
        end
    end

    // Narrow read data lags its strobe by one cycle: HI arrives in RdLo, LO in RdCap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg    <= 32'h0;
            rsp_rdata <= 64'h0;
        end else begin
            if (state == StRdLo) begin
                hi_reg <= mem_rdata;
            end
            if (state == StRdCap) begin
                rsp_rdata <= {hi_reg, mem_rdata};
            end
        end
    end

endmodule

// File: tb/tb_mem64_to32_bridge.sv
// Directed self-checking bench for mem64_to32_bridge with a small narrow-port RAM model.
// Responses are checked through an expected-data queue; BRIDGE_WR_ACK_EN adjusts write expectations.
module tb_mem64_to32_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_byte_en;
    logic [12:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        mem_we;
    logic        mem_rd;
    logic [3:0]  mem_byte_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        bd_we;
    logic [13:0] bd_addr;
    logic [31:0] bd_data;
    logic [31:0] ram [0:16383];

    logic [63:0] exp_q[$];
    logic [63:0] model_rdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem64_to32_bridge #(.ADDR_WIDTH(13)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_byte_en (req_byte_en),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_byte_en (mem_byte_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // RAM model: byte-masked writes, read data one cycle after mem_rd, garbage otherwise.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_en[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        mem_rdata <= mem_rd ? ram[mem_addr] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic we, input logic rd, input logic [3:0] be,
                           input logic [13:0] a, input logic [31:0] wd);
        chk({tag, "_we"}, 64'(mem_we), 64'(we));
        chk({tag, "_rd"}, 64'(mem_rd), 64'(rd));
        chk({tag, "_be"}, 64'(mem_byte_en), 64'(be));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
    endtask

    // Advance one cycle and score any response against the expected queue.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_rsp: observed rsp_valid=1 rdata=%h expected no response",
                       rsp_rdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] be, input logic [12:0] a,
                         input logic [63:0] d);
        req_valid   = 1'b1;
        req_we      = we;
        req_byte_en = be;
        req_addr    = a;
        req_wdata   = d;
    endtask

    // Called in the cycle after the last write beat.
    task automatic write_tail(input string tag);
`ifdef BRIDGE_WR_ACK_EN
        chk({tag, "_ack"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_busy"}, 64'(req_ready), 64'd0);
        tick();
`else
        chk({tag, "_noack"}, 64'(rsp_valid), 64'd0);
`endif
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_byte_en = 8'h0; req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        model_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_mem("reset", 1'b0, 1'b0, 4'h0, 14'd0, 32'h0);
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'h0);

        bd_we = 1'b1; bd_addr = 14'd10; bd_data = 32'hAAAA_0000;
        @(posedge clk); #1;
        bd_addr = 14'd11; bd_data = 32'h0000_BBBB;
        @(posedge clk); #1;
        bd_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // Read addr 5; request inputs change while busy and must be ignored.
        model_rdata = 64'hAAAA_0000_0000_BBBB;
        exp_q.push_back(model_rdata);
        drive(1'b0, 8'h00, 13'd5, 64'h0);
        chk("rd_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0; req_addr = 13'd7; req_we = 1'b1;
        chk_mem("rd_c1", 1'b0, 1'b1, 4'hF, 14'd10, 32'h0);
        chk("rd_c1_ready", 64'(req_ready), 64'd0);
        tick();
        chk_mem("rd_c2", 1'b0, 1'b1, 4'hF, 14'd11, 32'h0);
        tick();
        chk_mem("rd_c3", 1'b0, 1'b0, 4'h0, 14'd0, 32'h0);
        chk("rd_c3_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("rd_c4_rsp", 64'(rsp_valid), 64'd1);
        chk("rd_c4_ready", 64'(req_ready), 64'd0);
        tick();
        chk("rd_c5_ready", 64'(req_ready), 64'd1);
        chk("rd_c5_rsp", 64'(rsp_valid), 64'd0);

        // Reset asserted while in RD_LO drops the read.
        drive(1'b0, 8'hFF, 13'd5, 64'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstmid_pre_rd", 64'(mem_rd), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_mem("rstmid", 1'b0, 1'b0, 4'h0, 14'd0, 32'h0);
        chk("rstmid_ready", 64'(req_ready), 64'd1);
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_rsp_rdata", rsp_rdata, 64'h0);
        model_rdata = 64'h0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // Full write addr 5.
`ifdef BRIDGE_WR_ACK_EN
        exp_q.push_back(model_rdata);
`endif
        drive(1'b1, 8'hFF, 13'd5, 64'h1122_3344_5566_7788);
        chk("wf_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk_mem("wf_c1", 1'b1, 1'b0, 4'hF, 14'd10, 32'h1122_3344);
        tick();
        chk_mem("wf_c2", 1'b1, 1'b0, 4'hF, 14'd11, 32'h5566_7788);
        tick();
        chk_mem("wf_c3", 1'b0, 1'b0, 4'h0, 14'd0, 32'h0);
        write_tail("wf");

        // LO-only write: a single strobe.
`ifdef BRIDGE_WR_ACK_EN
        exp_q.push_back(model_rdata);
`endif
        drive(1'b1, 8'h0F, 13'd6, 64'hCAFE_BABE_DEAD_BEEF);
        tick();
        req_valid = 1'b0;
        chk_mem("wlo_c1", 1'b1, 1'b0, 4'hF, 14'd13, 32'hDEAD_BEEF);
        tick();
        chk("wlo_c2_we", 64'(mem_we), 64'd0);
        write_tail("wlo");

        // Split byte enables route to each half.
`ifdef BRIDGE_WR_ACK_EN
        exp_q.push_back(model_rdata);
`endif
        drive(1'b1, 8'h3C, 13'd8, 64'h0102_0304_0506_0708);
        tick();
        req_valid = 1'b0;
        chk_mem("wmix_c1", 1'b1, 1'b0, 4'h3, 14'd16, 32'h0102_0304);
        tick();
        chk_mem("wmix_c2", 1'b1, 1'b0, 4'hC, 14'd17, 32'h0506_0708);
        tick();
        write_tail("wmix");

        // All-zero write touches no memory.
`ifdef BRIDGE_WR_ACK_EN
        exp_q.push_back(model_rdata);
`endif
        drive(1'b1, 8'h00, 13'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        req_valid = 1'b0;
        chk_mem("wzero_c1", 1'b0, 1'b0, 4'h0, 14'd0, 32'h0);
        chk("wzero_c1_ready", 64'(req_ready), 64'd0);
        tick();
        chk("wzero_c2_we", 64'(mem_we), 64'd0);
        write_tail("wzero");

        // Back-to-back write then read with req_valid held high.
`ifdef BRIDGE_WR_ACK_EN
        exp_q.push_back(model_rdata);
`endif
        drive(1'b1, 8'hFF, 13'd9, 64'h0123_4567_89AB_CDEF);
        tick();
        req_we = 1'b0; req_byte_en = 8'h00; req_wdata = 64'h0;
        chk_mem("b2b_c1", 1'b1, 1'b0, 4'hF, 14'd18, 32'h0123_4567);
        tick();
        chk_mem("b2b_c2", 1'b1, 1'b0, 4'hF, 14'd19, 32'h89AB_CDEF);
        tick();
`ifdef BRIDGE_WR_ACK_EN
        chk("b2b_ack", 64'(rsp_valid), 64'd1);
        tick();
`endif
        chk("b2b_accept_ready", 64'(req_ready), 64'd1);
        model_rdata = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back(model_rdata);
        tick();
        req_valid = 1'b0;
        chk_mem("b2b_rd1", 1'b0, 1'b1, 4'hF, 14'd18, 32'h0);
        tick();
        chk_mem("b2b_rd2", 1'b0, 1'b1, 4'hF, 14'd19, 32'h0);
        tick();
        chk("b2b_rd3_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("b2b_rd4_rsp", 64'(rsp_valid), 64'd1);
        tick();
        chk("b2b_rd5_ready", 64'(req_ready), 64'd1);

        repeat (3) tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem64_to32_bridge.md
# mem64_to32_bridge

Initiator-side downsizer for the 32-bit port of the 64/32 dual-port simulation RAM. Accepts single 64-bit read/write requests from a 64-bit master and issues them as up to two 32-bit accesses on the narrow port. It reassembles read data into a 64-bit response. It sits between a BA22 64-bit bench master and the RAM's 32-bit port, so 64-bit traffic can be steered through either port.

## Interface
- ADDR_WIDTH, 13, 64-bit word address width; narrow address is ADDR_WIDTH+1 bits
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  bridge idle, request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_byte_en  in  8  byte enables, bit 7 = bits 63:56
- req_addr  in  ADDR_WIDTH  64-bit word address
- req_wdata  in  64  write data
- rsp_valid  out  1  one-cycle pulse, read data valid (and write ack, see Configuration)
- rsp_rdata  out  64  assembled read data
- mem_we  out  1  narrow-port write strobe
- mem_rd  out  1  narrow-port read strobe
- mem_byte_en  out  4  narrow-port byte enables
- mem_addr  out  ADDR_WIDTH+1  narrow word address
- mem_wdata  out  32  narrow write data
- mem_rdata  in  32  narrow read data, valid the cycle after mem_rd

## Operation
- Word mapping is fixed: mem_addr = {req_addr, 0} is bits 63:32 (HI), and {req_addr, 1} is bits 31:0 (LO). HI is always issued before LO.
- The request is registered on acceptance. Memory strobes are driven from registered state only.
- States: IDLE, WR_HI, WR_LO, RD_HI, RD_LO, RD_CAP, RSP.
- IDLE: req_ready=1. On accept, a write goes to WR_HI; a read goes to RD_HI.
- WR_HI: mem_we=1, mem_byte_en=be[7:4], mem_wdata=wdata[63:32]. Goes to WR_LO.
- WR_LO: mem_we=1, mem_byte_en=be[3:0], mem_wdata=wdata[31:0]. Goes to IDLE.
- Write beat skip: a beat whose 4-bit byte-enable half is zero issues no mem_we. A zero HI half means WR_LO is entered directly on accept. A zero LO half means WR_HI goes to IDLE. An all-zero write accesses no memory and the bridge returns to IDLE one cycle after accept.
- RD_HI: mem_rd=1, mem_byte_en=4'hF. Goes to RD_LO.
- RD_LO: mem_rd=1. Captures mem_rdata into hi_reg. Goes to RD_CAP.
- RD_CAP: loads rsp_rdata <= {hi_reg, mem_rdata} and sets rsp_valid. Goes to RSP.
- RSP: rsp_valid=1 for exactly this cycle. Goes to IDLE.
- Reads always fetch both words; req_byte_en is ignored for reads.
- Outside strobe states: mem_we=0, mem_rd=0, mem_byte_en=0, mem_addr=0, mem_wdata=0.
- No response backpressure. The master must consume rsp_valid in the cycle it is high.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, all mem_* outputs=0, state=IDLE, hi_reg=0.
- Write accepted at edge 0: HI strobe in cycle 1, LO strobe in cycle 2, req_ready high again in cycle 3.
- Read accepted at edge 0: mem_rd in cycles 1 and 2, rsp_valid in cycle 4, req_ready high again in cycle 5.
- Throughput: one write per 3 cycles; one read per 5 cycles.
- req_* inputs are sampled only at acceptance. Changes while req_ready=0 are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The pending request is dropped with no rsp_valid. A HI beat already written stays in memory.

## Configuration
- BRIDGE_WR_ACK_EN defined: every write also produces a one-cycle rsp_valid with rsp_rdata unchanged.
  - The pulse falls in the cycle after the last strobe.
  - For an all-zero write it falls in cycle 2.
  - Write latency to ready grows by one cycle.
- BRIDGE_WR_ACK_EN undefined: rsp_valid is asserted for reads only.

## Structure
- Shared package mem64_to32_bridge_pkg holds the state enum and the constants HALF_HI=1'b0 and HALF_LO=1'b1, which give the narrow-address LSB.
- Single module, no sub-module. The FSM, request register and hi_reg are all local.

## Test plan
- Reset mid-read: assert rst_n=0 in RD_LO -> all outputs 0 immediately, and no rsp_valid after reset is released.
- Full write, addr 5, be FF, data 0x1122334455667788:
  - cycle 1: mem_addr=10, be=F, wdata=0x11223344
  - cycle 2: mem_addr=11, wdata=0x55667788
- Partial write, be 0x0F -> only one strobe, mem_addr=11, be=F. be 0x00 -> no strobe, and req_ready back in cycle 2.
- Read, addr 5, with the RAM returning 0xAAAA0000 then 0x0000BBBB -> rsp_valid in cycle 4 with rsp_rdata=0xAAAA00000000BBBB.
- Back-to-back: req_valid held high with write then read -> second accept in cycle 3, mem_rd in cycles 4 and 5, and the read returns the data just written.
- With BRIDGE_WR_ACK_EN: be FF write -> rsp_valid in cycle 3, req_ready back in cycle 4. Without it -> no rsp_valid.
